uart_rx_fifo: RTL and testbench

- Receive-side byte buffer between the UART receiver (byte plus one-cycle data-valid pulse) and the byte consumer (display / user readout).
- Stores received bytes in arrival order and presents the oldest byte first-word-fall-through.
- The consumer advances with a single-cycle pop pulse, e.g. from the debounced pushbutton pulse.
- Tracks occupancy, overflow and a saturating count of dropped bytes so the user can see lost characters.

---
 rtl/uart_rx_fifo.sv | 74 +++++++
 tb/tb_uart_rx_fifo.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the byte consumer.
// First-word-fall-through head, occupancy count, sticky overflow and saturating drop counter.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              rd_pop,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt_q;
  logic              ovf_q;
  logic [7:0]        drop_q;

  logic do_pop, wr_en, drop;

  assign rd_valid = (cnt_q != '0);
  assign full     = (cnt_q == (ADDR_W+1)'(DEPTH));
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // A pop in the same cycle frees the slot, so a push into a full FIFO only drops without one.
  assign do_pop = rd_pop & rd_valid;
  assign wr_en  = wr_valid & (~full | do_pop);
  assign drop   = wr_valid & full & ~do_pop;

  // Storage is not reset; it is unobservable while empty.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // A drop in the clearing cycle wins and restarts the count at one.
      if (drop) begin
        ovf_q  <= 1'b1;
        if (clr_ovf)            drop_q <= 8'd1;
        else if (drop_q != '1)  drop_q <= drop_q + 1'b1;
      end else if (clr_ovf) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DW = 8, DEPTH = 16, AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_valid, rd_pop, clr_ovf;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, overflow;
  logic [AW:0]   count;
  logic [7:0]    drop_cnt;

  uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_pop(rd_pop), .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] mq[$];
  bit  m_ovf;
  int  m_drop;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: FIFO as a queue, actions evaluated from the pre-edge occupancy.
  task automatic model(input bit rst, input bit wv, input logic [7:0] wd, input bit pop, input bit clr);
    bit pop_ok, was_full, dropped;
    if (rst) begin
      mq.delete(); m_ovf = 0; m_drop = 0;
      return;
    end
    pop_ok   = pop && mq.size() > 0;
    was_full = mq.size() == DEPTH;
    dropped  = wv && was_full && !pop_ok;
    if (pop_ok) void'(mq.pop_front());
    if (wv && !dropped) mq.push_back(wd);
    if (dropped) begin
      m_ovf = 1;
      m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf = 0; m_drop = 0;
    end
  endtask

  task automatic check_model();
    chk("rd_valid", rd_valid, mq.size() != 0);
    chk("rd_data",  rd_data,  mq.size() != 0 ? int'(mq[0]) : 0);
    chk("count",    count,    mq.size());
    chk("full",     full,     mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic step(input bit wv, input logic [7:0] wd, input bit pop,
                      input bit clr = 0, input bit rst = 0);
    wr_valid = wv; wr_data = wd; rd_pop = pop; clr_ovf = clr; rst_n = !rst;
    @(posedge clk);
    model(rst, wv, wd, pop, clr);
    #1;
    check_model();
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) step(1, 8'(base + i), 0);
  endtask

  initial begin
    wr_valid = 0; wr_data = 0; rd_pop = 0; clr_ovf = 0; rst_n = 0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_count", count, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_data", rd_data, 0);

    // Three pushes, first byte visible one cycle after its push.
    step(1, 8'h41, 0);
    chk("first_valid", rd_valid, 1);
    chk("first_data", rd_data, 8'h41);
    step(1, 8'h42, 0);
    step(1, 8'h43, 0);
    chk("three_count", count, 3);
    step(0, 0, 1); chk("pop1", rd_data, 8'h42);
    step(0, 0, 1); chk("pop2", rd_data, 8'h43);
    step(0, 0, 1); chk("pop3_valid", rd_valid, 0); chk("pop3_data", rd_data, 0);

    // Fill then two drops.
    fill(16, 0);
    step(1, 8'h10, 0);
    step(1, 8'h11, 0);
    chk("ovf_full", full, 1); chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 2); chk("ovf_count", count, 16); chk("ovf_head", rd_data, 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", rd_data, i);
      step(0, 0, 1);
    end
    step(0, 0, 0, 1);
    chk("clr_ovf", overflow, 0);

    // Push+pop while full: no drop.
    fill(16, 0);
    step(1, 8'hAA, 1);
    chk("fullpp_ovf", overflow, 0); chk("fullpp_count", count, 16); chk("fullpp_head", rd_data, 1);
    for (int i = 0; i < 15; i++) step(0, 0, 1);
    chk("aa_last", rd_data, 8'hAA);
    step(0, 0, 1);

    // Pop on empty, then push+pop on empty.
    step(0, 0, 1);
    chk("empty_pop", count, 0);
    step(1, 8'h55, 1);
    chk("empty_pp_count", count, 1); chk("empty_pp_data", rd_data, 8'h55);
    step(0, 0, 1);

    // Interleaved traffic wraps the pointers several times.
    for (int i = 0; i < 40; i++) begin
      step(1, 8'($urandom), (i % 3) != 0);
    end
    while (mq.size() > 0) step(0, 0, 1);

    // Saturate the drop counter, then clear coincident with a drop.
    fill(16, 8'h80);
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), 0);
    chk("sat_drop", drop_cnt, 255);
    step(1, 8'h00, 0, 1);
    chk("clr_drop_ovf", overflow, 1); chk("clr_drop_cnt", drop_cnt, 1);
    while (mq.size() > 0) step(0, 0, 1);

    // Reset mid-stream with a push in the reset cycle.
    fill(5, 8'h30);
    chk("pre_rst_count", count, 5);
    step(1, 8'hEE, 0, 0, 1);
    chk("rst_count", count, 0); chk("rst_valid", rd_valid, 0); chk("rst_ovf", overflow, 0);
    step(0, 0, 0);
    chk("rst_no_push", count, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
